// File: rtl/lc3b_stage_fifo_pkg.sv
// Shared LC-3b pipeline types: opcodes, control word, NOP constant and the
// stage-buffer entry layout (payload width stays a parameter of the FIFO).
package lc3b_stage_fifo_pkg;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [3:0] {
      op_br  = 4'b0000,
      op_add = 4'b0001,
      op_ldb = 4'b0010,
      op_stb = 4'b0011,
      op_jsr = 4'b0100,
      op_and = 4'b0101,
      op_ldr = 4'b0110,
      op_str = 4'b0111,
      op_rti = 4'b1000,
      op_not = 4'b1001,
      op_ldi = 4'b1010,
      op_sti = 4'b1011,
      op_jmp = 4'b1100,
      op_shf = 4'b1101,
      op_lea = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef struct packed {
      lc3b_opcode  opcode;
      logic        load_cc;
      logic        load_regfile;
      logic [1:0]  alumux_sel;
      logic [1:0]  regfilemux_sel;
      logic        marmux_sel;
      logic [1:0]  pcmux_sel;
      logic        mem_read;
      logic        mem_write;
   } lc3b_control_word;

   // A BR with no condition bits and no register/CC writes retires as a no-op.
   localparam lc3b_control_word LC3B_CW_NOP = '{
      opcode:         op_br,
      load_cc:        1'b0,
      load_regfile:   1'b0,
      alumux_sel:     2'b00,
      regfilemux_sel: 2'b00,
      marmux_sel:     1'b0,
      pcmux_sel:      2'b00,
      mem_read:       1'b0,
      mem_write:      1'b0
   };

   typedef struct packed {
      lc3b_control_word ctrl;
      lc3b_word         pc;
   } lc3b_stage_entry;

endpackage

// File: rtl/lc3b_wrap_ptr.sv
// Modulo-DEPTH pointer with increment and synchronous clear; used for the
// read and write sides of the stage FIFO.
module lc3b_wrap_ptr #(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear_i,
   input  logic                       inc_i,
   output logic [$clog2(DEPTH)-1:0]   ptr_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] ptr_q, ptr_d;

   // Clear wins over increment so a flush always lands on slot 0.
   always_comb begin
      ptr_d = ptr_q;
      if (clear_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/lc3b_stage_fifo.sv
// Elastic LC-3b pipeline stage: DEPTH-entry FIFO of {ctrl, pc, payload} that shows a NOP when empty.
// Optional LC3B_STAGE_STATS_EN adds saturating stall_cycles / bubble_cycles counters.
module lc3b_stage_fifo
   import lc3b_stage_fifo_pkg::*;
#(
   parameter int DEPTH     = 2,
   parameter int PAYLOAD_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  lc3b_control_word        in_ctrl,
   input  lc3b_word                in_pc,
   input  logic [PAYLOAD_W-1:0]    in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output lc3b_control_word        out_ctrl,
   output lc3b_word                out_pc,
   output logic [PAYLOAD_W-1:0]    out_data,
`ifdef LC3B_STAGE_STATS_EN
   output logic [15:0]             stall_cycles,
   output logic [15:0]             bubble_cycles,
`endif
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic             ready_q, ready_d;
   logic             push, pop;

   lc3b_stage_entry      entry_q [DEPTH];
   logic [PAYLOAD_W-1:0] data_q  [DEPTH];

   assign push = in_valid & ready_q & ~flush;
   assign pop  = valid_q & out_ready & ~flush;

   lc3b_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (flush),
      .inc_i   (push),
      .ptr_o   (wr_ptr)
   );

   lc3b_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (flush),
      .inc_i   (pop),
      .ptr_o   (rd_ptr)
   );

   // Ready and valid are derived from next-state occupancy so neither output
   // has a combinational path from the opposite handshake.
   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
      valid_d = (count_d != '0);
      ready_d = (count_d < CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         count_q <= count_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         entry_q[wr_ptr] <= '{ctrl: in_ctrl, pc: in_pc};
         data_q[wr_ptr]  <= in_data;
      end
   end

   // Gating on valid_q keeps stale storage from ever reaching the next stage.
   always_comb begin
      out_ctrl = LC3B_CW_NOP;
      out_pc   = '0;
      out_data = '0;
      if (valid_q) begin
         out_ctrl = entry_q[rd_ptr].ctrl;
         out_pc   = entry_q[rd_ptr].pc;
         out_data = data_q[rd_ptr];
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = valid_q;
   assign count     = count_q;

`ifdef LC3B_STAGE_STATS_EN
   logic [15:0] stall_q, bubble_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else if (flush) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (valid_q && !out_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
         end
         if (!valid_q && out_ready && bubble_q != 16'hFFFF) begin
            bubble_q <= bubble_q + 16'd1;
         end
      end
   end

   assign stall_cycles  = stall_q;
   assign bubble_cycles = bubble_q;
`endif

endmodule
